// File: rtl/cpu_seq_pkg.sv
// ---------------------------------------------------------------------------
// cpu_seq_pkg
// Shared definitions for the CPU instruction-cycle sequencer:
//   - seq_state_t : sequencer FSM states (IDLE, RUN, STEP_WAIT)
//   - PH_*        : phase numbers of the four instruction phases
//   - phase_onehot: maps a phase number to its one-hot strobe vector,
//                   bit 0 = fetch, 1 = decode, 2 = exec, 3 = writeback
// ---------------------------------------------------------------------------
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STEP_WAIT = 2'd2
    } seq_state_t;

    localparam logic [1:0] PH_FETCH  = 2'd0;
    localparam logic [1:0] PH_DECODE = 2'd1;
    localparam logic [1:0] PH_EXEC   = 2'd2;
    localparam logic [1:0] PH_WB     = 2'd3;

    function automatic logic [3:0] phase_onehot(input logic [1:0] ph);
        return 4'b0001 << ph;
    endfunction

endpackage

// File: rtl/seq_phase_ctr.sv
// ---------------------------------------------------------------------------
// seq_phase_ctr
// Two-bit instruction phase register.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset, forces phase to 0
//   en    - advance the phase by one (wraps 3 -> 0)
//   clr   - load phase 0; takes priority over en
//   phase - current phase value
// ---------------------------------------------------------------------------
module seq_phase_ctr
    import cpu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output logic [1:0] phase
);

    // Phase register: clearing wins over advancing so the controller can
    // end an instruction and restart at fetch in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= PH_FETCH;
        end else if (clr) begin
            phase <= PH_FETCH;
        end else if (en) begin
            phase <= phase + 2'd1;
        end
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_phase_sequencer
// Instruction-cycle controller for the structural CPU. Steps through the
// phases T0 fetch, T1 decode, T2 execute, T3 writeback, with support for
// 3-phase short instructions, stall, single-step, halt, a retired
// instruction counter and a sticky stall-timeout flag.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   start               - leave IDLE and start executing
//   halt_req            - stop after the current instruction
//   stall               - freeze the current phase this cycle
//   short_instr         - instruction ends after T2 (looked at in T2 only)
//   step_mode, step     - pause after each instruction / release one
//   phase               - current phase 0..3
//   fetch_en..wb_en     - one-hot datapath phase strobes
//   instr_done          - last phase of an instruction completes now
//   busy                - sequencer is not IDLE
//   instr_count         - retired instruction count (wraps)
//   stall_err           - sticky stall-timeout flag
// ---------------------------------------------------------------------------
module cpu_phase_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MAX_STALL = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             short_instr,
    input  logic             step_mode,
    input  logic             step,
    output logic [1:0]       phase,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             wb_en,
    output logic             instr_done,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count,
    output logic             stall_err
);

    localparam int STALL_W = $clog2(MAX_STALL + 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_STALL);
    localparam logic [STALL_W-1:0] STALL_LAST  = STALL_W'(MAX_STALL - 1);

    seq_state_t         state;
    seq_state_t         state_next;
    logic               halt_pending;
    logic [STALL_W-1:0] stall_cnt;
    logic               phase_en;
    logic               phase_clr;
    logic [3:0]         strobe_vec;
    logic               instr_end;

    seq_phase_ctr u_phase_ctr (
        .clk   (clk),
        .reset (reset),
        .en    (phase_en),
        .clr   (phase_clr),
        .phase (phase)
    );

    // Next-state and output decode. Strobes and instr_done depend on the
    // live stall/short_instr inputs so a stalled phase never fires its
    // strobe. Reset dominates, so outputs are silenced while it is high.
    always_comb begin
        state_next = state;
        phase_en   = 1'b0;
        phase_clr  = 1'b0;
        strobe_vec = 4'b0000;
        instr_done = 1'b0;
        instr_end  = !stall && ((phase == PH_WB) ||
                                ((phase == PH_EXEC) && short_instr));

        unique case (state)
            IDLE: begin
                phase_clr = 1'b1;
                if (start) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                if (!stall) begin
                    strobe_vec = phase_onehot(phase);
                end
                if (instr_end) begin
                    instr_done = 1'b1;
                    phase_clr  = 1'b1;
                    if (halt_req || halt_pending) begin
                        state_next = IDLE;
                    end else if (step_mode) begin
                        state_next = STEP_WAIT;
                    end else begin
                        state_next = RUN;
                    end
                end else if (!stall) begin
                    phase_en = 1'b1;
                end
            end

            STEP_WAIT: begin
                phase_clr = 1'b1;
                if (halt_req) begin
                    state_next = IDLE;
                end else if (step) begin
                    state_next = RUN;
                end
            end

            default: begin
                state_next = IDLE;
                phase_clr  = 1'b1;
            end
        endcase

        if (reset) begin
            strobe_vec = 4'b0000;
            instr_done = 1'b0;
        end
    end

    // State, halt bookkeeping and counters. A halt request seen anywhere in
    // RUN is remembered until the sequencer actually reaches IDLE, so the
    // running instruction always completes. The stall counter saturates at
    // the limit; the error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            halt_pending <= 1'b0;
            instr_count  <= '0;
            stall_cnt    <= '0;
            stall_err    <= 1'b0;
        end else begin
            state <= state_next;

            if (state_next == IDLE) begin
                halt_pending <= 1'b0;
            end else if ((state == RUN) && halt_req) begin
                halt_pending <= 1'b1;
            end

            if (instr_done) begin
                instr_count <= instr_count + 1'b1;
            end

            if ((state == RUN) && stall) begin
                if (stall_cnt != STALL_LIMIT) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
                if (stall_cnt >= STALL_LAST) begin
                    stall_err <= 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

    assign {wb_en, exec_en, decode_en, fetch_en} = strobe_vec;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_phase_sequencer
// Self-checking bench for cpu_phase_sequencer. Two instances share the
// stimulus: the default 8-bit counter and a 2-bit counter that exercises
// wrap-around. Expected values come from a behavioural model that tracks
// the sequencer in terms of "running / paused / idle" and instruction
// lengths rather than the RTL's encoding.
// ---------------------------------------------------------------------------
module tb_cpu_phase_sequencer;

    localparam int MAX_STALL = 15;

    logic       clk;
    logic       reset, start, halt_req, stall, short_instr, step_mode, step;

    logic [1:0] phase, phase2;
    logic       fetch_en, decode_en, exec_en, wb_en;
    logic       fetch_en2, decode_en2, exec_en2, wb_en2;
    logic       instr_done, instr_done2, busy, busy2, stall_err, stall_err2;
    logic [7:0] instr_count;
    logic [1:0] instr_count2;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_run, m_wait, m_pend, m_err;
    int m_phase, m_count, m_stall_run;

    cpu_phase_sequencer #(.CNT_W(8), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .stall(stall), .short_instr(short_instr), .step_mode(step_mode),
        .step(step), .phase(phase), .fetch_en(fetch_en),
        .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
        .instr_done(instr_done), .busy(busy), .instr_count(instr_count),
        .stall_err(stall_err)
    );

    cpu_phase_sequencer #(.CNT_W(2), .MAX_STALL(MAX_STALL)) dut_narrow (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .stall(stall), .short_instr(short_instr), .step_mode(step_mode),
        .step(step), .phase(phase2), .fetch_en(fetch_en2),
        .decode_en(decode_en2), .exec_en(exec_en2), .wb_en(wb_en2),
        .instr_done(instr_done2), .busy(busy2), .instr_count(instr_count2),
        .stall_err(stall_err2)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic checkOutput();
        logic [3:0] exp_strb;
        logic       exp_done;
        logic       exp_busy;
        bool_dummy: begin end
        exp_strb = 4'b0000;
        exp_done = 1'b0;
        if (m_run && !reset && !stall) begin
            exp_strb[m_phase] = 1'b1;
            exp_done = (m_phase == 3) || (m_phase == 2 && short_instr);
        end
        exp_busy = m_run || m_wait;
        checkVal("phase",      32'(phase),      32'(m_phase));
        checkVal("strobes",    32'({wb_en, exec_en, decode_en, fetch_en}),
                 32'(exp_strb));
        checkVal("instr_done", 32'(instr_done), 32'(exp_done));
        checkVal("busy",       32'(busy),       32'(exp_busy));
        checkVal("stall_err",  32'(stall_err),  32'(m_err));
        checkVal("instr_count", 32'(instr_count), 32'(m_count % 256));
        checkVal("narrow_ctrl",
                 32'({phase2, wb_en2, exec_en2, decode_en2, fetch_en2,
                      instr_done2, busy2, stall_err2}),
                 32'({m_phase[1:0], exp_strb, exp_done, exp_busy, m_err}));
        checkVal("narrow_count", 32'(instr_count2), 32'(m_count % 4));
    endtask

    // Advance the model across one rising edge with the current inputs
    task automatic modelStep();
        bit ends;
        if (reset) begin
            m_run = 0; m_wait = 0; m_pend = 0; m_err = 0;
            m_phase = 0; m_count = 0; m_stall_run = 0;
        end else if (m_wait) begin
            if (halt_req) m_wait = 0;
            else if (step) begin m_wait = 0; m_run = 1; end
        end else if (!m_run) begin
            if (start) m_run = 1;
        end else begin
            if (halt_req) m_pend = 1;
            if (stall) begin
                m_stall_run++;
                if (m_stall_run >= MAX_STALL) m_err = 1;
            end else begin
                m_stall_run = 0;
                ends = (m_phase == 3) || (m_phase == 2 && short_instr);
                if (ends) begin
                    m_count++;
                    m_phase = 0;
                    if (m_pend) begin
                        m_run = 0; m_pend = 0;
                    end else if (step_mode) begin
                        m_run = 0; m_wait = 1;
                    end
                end else begin
                    m_phase++;
                end
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check, then clock
    task automatic applyStimulus(input bit r, input bit st, input bit hr,
                                 input bit sl, input bit sh, input bit sm,
                                 input bit sp);
        reset = r; start = st; halt_req = hr; stall = sl;
        short_instr = sh; step_mode = sm; step = sp;
        #1;
        checkOutput();
        modelStep();
        @(negedge clk);
    endtask

    task automatic quietCycles(input int n, input bit sh, input bit sm);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, sh, sm, 0);
    endtask

    initial begin
        bit r_r, r_st, r_hr, r_sl, r_sh, r_sm, r_sp;

        m_run = 0; m_wait = 0; m_pend = 0; m_err = 0;
        m_phase = 0; m_count = 0; m_stall_run = 0;
        reset = 1; start = 0; halt_req = 0; stall = 0;
        short_instr = 0; step_mode = 0; step = 0;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] basic 4-phase run");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        quietCycles(8, 0, 0);
        checkVal("plan_two_instr", 32'(instr_count), 32'd2);

        $display("[TB] short instructions");
        quietCycles(6, 1, 0);

        $display("[TB] stall at decode");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0);
        quietCycles(4, 0, 0);

        $display("[TB] stall timeout");
        for (int i = 0; i < MAX_STALL; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0);
        quietCycles(2, 0, 0);
        checkVal("plan_stall_err", 32'(stall_err), 32'd1);

        $display("[TB] halt at decode, then restart");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        quietCycles(5, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        quietCycles(3, 0, 0);

        $display("[TB] single step");
        applyStimulus(1, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 0);
        quietCycles(9, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        quietCycles(5, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 1, 0);
        quietCycles(2, 0, 1);

        $display("[TB] reset mid-instruction and counter wrap");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        quietCycles(2, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        quietCycles(20, 0, 0);
        checkVal("plan_wrap_narrow", 32'(instr_count2), 32'd1);
        checkVal("plan_wrap_wide",   32'(instr_count),  32'd5);

        $display("[TB] randomized traffic");
        r_sm = 0;
        for (int i = 0; i < 600; i++) begin
            r_r  = ($urandom_range(63) == 0);
            r_st = ($urandom_range(3) == 0);
            r_hr = ($urandom_range(15) == 0);
            r_sl = ($urandom_range(4) == 0);
            r_sh = ($urandom_range(2) == 0);
            r_sp = ($urandom_range(3) == 0);
            if ($urandom_range(15) == 0) r_sm = ~r_sm;
            applyStimulus(r_r, r_st, r_hr, r_sl, r_sh, r_sm, r_sp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
- Instruction-cycle controller for the structural CPU.
- Drives a 2-bit phase counter through T0 (fetch), T1 (decode), T2 (execute) and T3 (writeback).
- Emits one-hot datapath enable strobes, supports 3-phase short instructions, stall, single-step and halt, and counts retired instructions.
- Sits between the top-level run control and the datapath register enables.

Parameters:
- CNT_W, 8: width of the retired-instruction counter.
- MAX_STALL, 15: consecutive stalled cycles tolerated before stall_err is set; must be at least 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset. It is sampled on the clk rising edge and dominates all other inputs.
- start  in  1  leave IDLE and begin execution; ignored outside IDLE.
- halt_req  in  1  request to stop after the current instruction completes.
- stall  in  1  freeze the current phase for this cycle.
- short_instr  in  1  current instruction ends after T2; sampled only in T2.
- step_mode  in  1  1 = pause in STEP_WAIT after every instruction.
- step  in  1  release one instruction from STEP_WAIT.
- phase  out  2  current phase: 0=T0, 1=T1, 2=T2, 3=T3.
- fetch_en  out  1  T0 strobe.
- decode_en  out  1  T1 strobe.
- exec_en  out  1  T2 strobe.
- wb_en  out  1  T3 strobe.
- instr_done  out  1  final phase of an instruction completes this cycle.
- busy  out  1  state is not IDLE.
- instr_count  out  CNT_W  number of retired instructions.
- stall_err  out  1  sticky stall-timeout flag.

Behaviour:
- Reset values:
  - state IDLE, phase 0.
  - All strobes 0, instr_done 0, busy 0.
  - instr_count 0, stall_err 0, halt_pending 0, stall counter 0.
- States: IDLE, RUN, STEP_WAIT. State, phase and counters are registered; strobes and instr_done are combinational from the registered state/phase and the current inputs.
- IDLE:
  - Outputs quiet, phase held at 0.
  - start=1 moves to RUN; the first fetch_en appears the following cycle.
- RUN, strobe generation:
  - The strobe for the current phase equals !stall. At most one strobe is high in any cycle.
- RUN, stall:
  - stall=1 holds phase and asserts no strobe.
  - The stall counter increments on each stalled cycle and clears on any non-stalled cycle.
  - When the counter reaches MAX_STALL, stall_err is set and stays set until reset. The stall itself continues to be honoured.
- RUN, end of instruction:
  - An instruction ends when stall=0 and either phase=3, or phase=2 with short_instr=1.
  - That cycle: instr_done=1, instr_count increments (wraps modulo 2^CNT_W), and phase returns to 0.
  - Next state, in priority order: IDLE if halt_req=1 or halt_pending=1; otherwise STEP_WAIT if step_mode=1; otherwise RUN.
  - Otherwise, with stall=0, phase increments by 1.
- halt_req:
  - Asserted in RUN at any phase (including stalled cycles), it sets halt_pending.
  - halt_pending clears on entry to IDLE.
  - The current instruction is never aborted by a halt.
- STEP_WAIT:
  - busy=1, strobes 0, phase 0.
  - halt_req=1 moves to IDLE (halt takes priority over step).
  - Otherwise step=1 moves to RUN, and fetch_en appears the next cycle.
- Simultaneous events:
  - start in RUN or STEP_WAIT is ignored.
  - short_instr outside T2 is ignored.
  - stall together with halt_req: the stall is honoured and the halt is recorded.
- Reset mid-instruction returns everything to reset values on the next edge. No instr_done is produced.

Decomposition:
- Package cpu_seq_pkg:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, STEP_WAIT=2'd2.
  - Phase constants: PH_FETCH=0, PH_DECODE=1, PH_EXEC=2, PH_WB=3.
- Sub-module seq_phase_ctr:
  - 2-bit phase register with synchronous reset, en (advance) and clr (load 0).
  - Instantiated once; the FSM drives en and clr.

Test Plan:
- Reset, then start pulse with no other inputs, for 8 cycles → phases 0,1,2,3,0,1,2,3. fetch, decode, exec and wb strobes assert in that order; instr_done high on each T3; instr_count=2.
- short_instr=1 held while running → phase sequence 0,1,2,0,1,2. instr_done is asserted at each T2; instr_count increments every 3 cycles.
- stall=1 for 3 cycles at T1 → phase stays 1 and decode_en=0 for those 3 cycles. decode_en fires once after release; stall_err=0. A separate case stalls for MAX_STALL=15 cycles → stall_err=1, still 1 after the stall ends.
- halt_req pulse at T1 → T2 and T3 still complete, instr_done asserted, then IDLE with busy=0 and phase=0. A later start resumes at T0.
- step_mode=1 → exactly one instruction runs, then STEP_WAIT with busy=1 and no strobes for 5 idle cycles. A step pulse runs the next instruction. halt_req in STEP_WAIT → IDLE.
- reset asserted at T2 → next edge gives IDLE, phase=0, instr_count=0, and no instr_done. With CNT_W=2, 5 instructions give instr_count=1 (wrap).
